// File: rtl/jstk_spi_responder_pkg.sv
// Shared constants, FSM states and the frame-byte map for the PmodJSTK SPI responder.
package jstk_spi_responder_pkg;

    localparam int unsigned JSTK_NUM_BYTES = 5;

    localparam logic [2:0] JSTK_BYTE_XL  = 3'd0;
    localparam logic [2:0] JSTK_BYTE_XH  = 3'd1;
    localparam logic [2:0] JSTK_BYTE_YL  = 3'd2;
    localparam logic [2:0] JSTK_BYTE_YH  = 3'd3;
    localparam logic [2:0] JSTK_BYTE_BTN = 3'd4;

    localparam logic [5:0] JSTK_CMD_PREFIX = 6'b100000;

    typedef enum logic {
        StIdle,
        StShift
    } jstk_state_e;

    // Snapshot layout is {btn[2:0], y[9:0], x[9:0]}.
    function automatic logic [7:0] jstk_frame_byte(input logic [22:0] snap, input logic [2:0] idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            JSTK_BYTE_XL:  b = snap[7:0];
            JSTK_BYTE_XH:  b = {6'b0, snap[9:8]};
            JSTK_BYTE_YL:  b = snap[17:10];
            JSTK_BYTE_YH:  b = {6'b0, snap[19:18]};
            JSTK_BYTE_BTN: b = {5'b0, snap[22:20]};
            default:       b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/jstk_spi_responder_edge_sync.sv
// Multi-flop synchroniser for one SPI pin with registered rise/fall pulses.
module jstk_spi_responder_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= w_level;
            r_rise <= w_level & ~r_prev;
            r_fall <= ~w_level & r_prev;
        end
    end

    assign o_level = w_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 slave emulating the PmodJSTK: returns snapshotted X/Y/button bytes and
// decodes the LED command carried in byte 0.
module jstk_spi_responder
    import jstk_spi_responder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned NUM_BYTES   = JSTK_NUM_BYTES,
    parameter logic [5:0]  CMD_PREFIX  = JSTK_CMD_PREFIX
) (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_ss,
    input  logic       i_sclk,
    input  logic       i_mosi,
    output logic       o_miso,
    input  logic [9:0] i_x_in,
    input  logic [9:0] i_y_in,
    input  logic [2:0] i_btn_in,
    output logic [1:0] o_led_out,
    output logic       o_xfer_done,
    output logic       o_frame_err
);

    logic w_ss_level, w_ss_rise, w_ss_fall;
    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    jstk_spi_responder_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ss (
        .i_clk(i_clk), .i_clr(i_clr), .i_d(i_ss),
        .o_level(w_ss_level), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
    );

    jstk_spi_responder_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .i_clk(i_clk), .i_clr(i_clr), .i_d(i_sclk),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    jstk_spi_responder_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .i_clk(i_clk), .i_clr(i_clr), .i_d(i_mosi),
        .o_level(w_mosi), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = ^{w_ss_level, w_sclk_level, w_mosi_rise, w_mosi_fall};

    jstk_state_e r_state, w_state_nxt;
    logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
    logic [2:0]  r_byte_cnt, w_byte_cnt_nxt;
    logic [7:0]  r_tx, w_tx_nxt;
    logic [7:0]  r_rx, w_rx_nxt;
    logic [22:0] r_snap, w_snap_nxt;
    logic        r_miso, w_miso_nxt;
    logic [1:0]  r_led, w_led_nxt;
    logic        r_done, w_done_nxt;
    logic        r_err, w_err_nxt;
    logic        r_cmd_chk, w_cmd_chk_nxt;
    logic [7:0]  w_next_byte;

    assign w_next_byte = (32'(r_byte_cnt) >= NUM_BYTES) ? 8'h00
                                                         : jstk_frame_byte(r_snap, r_byte_cnt);

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_byte_cnt_nxt = r_byte_cnt;
        w_tx_nxt       = r_tx;
        w_rx_nxt       = r_rx;
        w_snap_nxt     = r_snap;
        w_miso_nxt     = r_miso;
        w_led_nxt      = r_led;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_cmd_chk_nxt  = 1'b0;

        // Command byte is judged one clk after its last bit lands in rx.
        if (r_cmd_chk && (r_rx[7:2] == CMD_PREFIX)) begin
            w_led_nxt = r_rx[1:0];
        end

        unique case (r_state)
            StIdle: begin
                if (w_ss_fall) begin
                    w_snap_nxt     = {i_btn_in, i_y_in, i_x_in};
                    w_tx_nxt       = jstk_frame_byte(w_snap_nxt, JSTK_BYTE_XL);
                    w_miso_nxt     = w_tx_nxt[7];
                    w_bit_cnt_nxt  = 3'd0;
                    w_byte_cnt_nxt = 3'd0;
                    w_state_nxt    = StShift;
                end
            end
            StShift: begin
                // SS rise wins over any coincident SCLK edge.
                if (w_ss_rise) begin
                    if ((r_bit_cnt == 3'd0) && (32'(r_byte_cnt) >= NUM_BYTES)) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                    w_miso_nxt  = 1'b0;
                    w_state_nxt = StIdle;
                end else if (w_sclk_rise) begin
                    w_rx_nxt      = {r_rx[6:0], w_mosi};
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_byte_cnt_nxt = (r_byte_cnt == 3'd7) ? 3'd7 : r_byte_cnt + 3'd1;
                        w_cmd_chk_nxt  = (r_byte_cnt == 3'd0);
                    end
                end else if (w_sclk_fall) begin
                    if (r_bit_cnt == 3'd0) begin
                        w_tx_nxt = w_next_byte;
                    end else begin
                        w_tx_nxt = {r_tx[6:0], 1'b0};
                    end
                    w_miso_nxt = w_tx_nxt[7];
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state    <= StIdle;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 3'd0;
            r_tx       <= 8'h00;
            r_rx       <= 8'h00;
            r_snap     <= 23'd0;
            r_miso     <= 1'b0;
            r_led      <= 2'b00;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cmd_chk  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_tx       <= w_tx_nxt;
            r_rx       <= w_rx_nxt;
            r_snap     <= w_snap_nxt;
            r_miso     <= w_miso_nxt;
            r_led      <= w_led_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_cmd_chk  <= w_cmd_chk_nxt;
        end
    end

    assign o_miso      = r_miso;
    assign o_led_out   = r_led;
    assign o_xfer_done = r_done;
    assign o_frame_err = r_err;

endmodule

// File: tb/tb_jstk_spi_responder.sv
// Directed bench for jstk_spi_responder: a frame-level joystick model checks every MISO bit,
// pulse counts and LED state, with literal expectations pinning the model.
module tb_jstk_spi_responder;

    logic       clk = 1'b0;
    logic       clr, ss, sclk, mosi;
    logic       miso, done, err;
    logic [9:0] x, y;
    logic [2:0] btn;
    logic [1:0] led;

    always #5 clk = ~clk;

    jstk_spi_responder dut (
        .i_clk(clk), .i_clr(clr), .i_ss(ss), .i_sclk(sclk), .i_mosi(mosi),
        .o_miso(miso), .i_x_in(x), .i_y_in(y), .i_btn_in(btn),
        .o_led_out(led), .o_xfer_done(done), .o_frame_err(err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_done   = 0;
    int n_err    = 0;

    logic       m_active = 1'b0;
    int         m_byte, m_bit;
    int         m_x, m_y, m_btn;
    logic [1:0] m_led;
    logic [7:0] got [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Joystick reply byte derived arithmetically from the frame's snapshot.
    function automatic logic [7:0] model_byte(input int idx);
        case (idx)
            0:       return 8'(m_x % 256);
            1:       return 8'(m_x / 256);
            2:       return 8'(m_y % 256);
            3:       return 8'(m_y / 256);
            4:       return 8'(m_btn);
            default: return 8'h00;
        endcase
    endfunction

    // Master samples MISO on each SCLK rise.
    always @(posedge sclk) begin : cmp_miso
        logic [7:0] eb;
        eb = model_byte(m_byte);
        if (m_active) begin
            check("miso_bit", 32'(miso), 32'(eb[7-m_bit]));
            if (m_byte < 8) got[m_byte][7-m_bit] = miso;
        end
    end

    always @(negedge clk) begin
        n_done += int'(done);
        n_err  += int'(err);
        if (done || err) check("pulse_excl", 32'(done & err), 32'd0);
    end

    task automatic half();
        repeat (50) @(negedge clk);
    endtask

    task automatic start_frame();
        n_done = 0;
        n_err  = 0;
        for (int i = 0; i < 8; i++) got[i] = 8'hEE;
        m_x = int'(x);
        m_y = int'(y);
        m_btn = int'(btn);
        m_byte = 0;
        m_bit = 0;
        ss = 1'b0;
        m_active = 1'b1;
    endtask

    task automatic clock_bit(input logic b);
        mosi = b;
        half();
        sclk = 1'b1;
        half();
        m_bit++;
        if (m_bit == 8) begin
            m_bit = 0;
            m_byte++;
        end
        sclk = 1'b0;
    endtask

    task automatic frame(input logic [7:0] cmd, input int nbytes, input int tail,
                         input int chg_byte, input logic [9:0] chg_x);
        int total;
        bit exp_done;
        start_frame();
        total = nbytes * 8 + tail;
        for (int b = 0; b < total; b++) begin
            if (b == chg_byte * 8) x = chg_x;
            clock_bit((b < 8) ? cmd[7-b] : 1'(b % 2));
        end
        half();
        ss = 1'b1;
        m_active = 1'b0;
        repeat (20) @(negedge clk);
        if (nbytes >= 1 && cmd[7:2] == 6'b100000) m_led = cmd[1:0];
        exp_done = (tail == 0) && (nbytes >= 5);
        check("xfer_done_cnt", 32'(n_done), exp_done ? 32'd1 : 32'd0);
        check("frame_err_cnt", 32'(n_err), exp_done ? 32'd0 : 32'd1);
        check("miso_idle", 32'(miso), 32'd0);
        check("led_out", 32'(led), 32'(m_led));
    endtask

    task automatic reset_frame();
        logic [7:0] cmd;
        cmd = 8'h81;
        start_frame();
        for (int b = 0; b < 12; b++) begin
            if (b == 10) begin
                m_active = 1'b0;
                clr = 1'b1;
                repeat (3) @(negedge clk);
                check("rst_miso", 32'(miso), 32'd0);
                check("rst_led", 32'(led), 32'd0);
                check("rst_pulse", 32'(done | err), 32'd0);
                clr = 1'b0;
                m_led = 2'b00;
            end
            clock_bit((b < 8) ? cmd[7-b] : 1'b1);
            if (b == 7) check("led_pre_rst", 32'(led), 32'h1);
        end
        half();
        ss = 1'b1;
        repeat (20) @(negedge clk);
        check("rst_no_done", 32'(n_done), 32'd0);
        check("rst_no_err", 32'(n_err), 32'd0);
        check("rst_miso_after", 32'(miso), 32'd0);
        check("rst_led_after", 32'(led), 32'd0);
    endtask

    initial begin
        clr = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        x = '0; y = '0; btn = '0; m_led = 2'b00;
        repeat (5) @(negedge clk);
        check("reset_miso", 32'(miso), 32'd0);
        check("reset_led", 32'(led), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        clr = 1'b0;
        repeat (10) @(negedge clk);

        // Nominal frame
        x = 10'h2A5; y = 10'h13C; btn = 3'b101;
        frame(8'h83, 5, 0, -1, 10'h0);
        check("nom_b0", 32'(got[0]), 32'hA5);
        check("nom_b1", 32'(got[1]), 32'h02);
        check("nom_b2", 32'(got[2]), 32'h3C);
        check("nom_b3", 32'(got[3]), 32'h01);
        check("nom_b4", 32'(got[4]), 32'h05);
        check("nom_led", 32'(led), 32'h3);

        // Bad command prefix leaves LEDs alone
        frame(8'h43, 5, 0, -1, 10'h0);
        check("bad_led", 32'(led), 32'h3);
        check("bad_b2", 32'(got[2]), 32'h3C);

        // X changes mid-frame; snapshot holds
        frame(8'h82, 5, 0, 1, 10'h001);
        check("snap_b0", 32'(got[0]), 32'hA5);
        check("snap_b1", 32'(got[1]), 32'h02);
        check("snap_led", 32'(led), 32'h2);
        frame(8'h83, 5, 0, -1, 10'h0);
        check("next_b0", 32'(got[0]), 32'h01);
        check("next_b1", 32'(got[1]), 32'h00);

        // Abort after 3 bits of byte 2, then a clean frame
        frame(8'h83, 2, 3, -1, 10'h0);
        check("abort_err", 32'(n_err), 32'd1);
        x = 10'h2A5;
        frame(8'h80, 5, 0, -1, 10'h0);
        check("post_abort_b0", 32'(got[0]), 32'hA5);
        check("post_abort_led", 32'(led), 32'h0);

        // Overrun: seven bytes
        frame(8'h83, 7, 0, -1, 10'h0);
        check("ovr_b4", 32'(got[4]), 32'h05);
        check("ovr_b5", 32'(got[5]), 32'h00);
        check("ovr_b6", 32'(got[6]), 32'h00);

        // Reset mid-frame, then a clean frame
        reset_frame();
        frame(8'h83, 5, 0, -1, 10'h0);
        check("post_rst_b3", 32'(got[3]), 32'h01);
        check("post_rst_led", 32'(led), 32'h3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
